// File: rtl/mux_key_arbiter.sv
// Round-robin shared key->data lookup table with a valid/ready response channel.
// Optional MUX_KEY_ARBITER_FIXED_PRIO_EN: fixed priority (lowest index wins) instead of round-robin.
module mux_key_arbiter #(
  parameter int NR_REQ   = 4,
  parameter int NR_KEY   = 4,
  parameter int KEY_LEN  = 2,
  parameter int DATA_LEN = 4,
  localparam int ID_W    = $clog2(NR_REQ),
  localparam int IDX_W   = (NR_KEY > 1) ? $clog2(NR_KEY) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NR_REQ-1:0]         req_valid,
  input  logic [NR_REQ*KEY_LEN-1:0] req_key,
  output logic [NR_REQ-1:0]         req_ready,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_LEN-1:0]       rsp_data,
  output logic                      rsp_hit,
  input  logic [DATA_LEN-1:0]       default_out,
  input  logic                      cfg_we,
  input  logic [IDX_W-1:0]          cfg_idx,
  input  logic [KEY_LEN-1:0]        cfg_key,
  input  logic [DATA_LEN-1:0]       cfg_data
);

  typedef enum logic {IDLE, RESP} state_t;

  state_t              state;
  logic [NR_KEY-1:0]   ent_valid;
  logic [KEY_LEN-1:0]  ent_key  [NR_KEY];
  logic [DATA_LEN-1:0] ent_data [NR_KEY];

  logic [NR_REQ-1:0]   grant;
  logic [ID_W-1:0]     gidx;
  logic                found;
  int                  cand;
  logic [KEY_LEN-1:0]  key_sel;
  logic                lk_hit;
  logic [DATA_LEN-1:0] lk_data;

`ifndef MUX_KEY_ARBITER_FIXED_PRIO_EN
  logic [ID_W-1:0]     rr_ptr;
`endif

  // Search starts one past the last served requester so it gets lowest priority.
  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 0; k < NR_REQ; k++) begin
`ifdef MUX_KEY_ARBITER_FIXED_PRIO_EN
      cand = k;
`else
      cand = (int'(rr_ptr) + 1 + k) % NR_REQ;
`endif
      if (!found && req_valid[cand]) begin
        grant[cand] = 1'b1;
        gidx        = ID_W'(cand);
        found       = 1'b1;
      end
    end
  end

  // Every matching valid entry contributes; duplicate keys OR together.
  always_comb begin
    key_sel = req_key[int'(gidx)*KEY_LEN +: KEY_LEN];
    lk_hit  = 1'b0;
    lk_data = '0;
    for (int e = 0; e < NR_KEY; e++) begin
      if (ent_valid[e] && (ent_key[e] == key_sel)) begin
        lk_hit  = 1'b1;
        lk_data = lk_data | ent_data[e];
      end
    end
  end

  assign req_ready = (state == IDLE) ? grant : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ent_valid <= '0;
      for (int e = 0; e < NR_KEY; e++) begin
        ent_key[e]  <= '0;
        ent_data[e] <= '0;
      end
`ifndef MUX_KEY_ARBITER_FIXED_PRIO_EN
      rr_ptr    <= ID_W'(NR_REQ - 1);
`endif
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      rsp_hit   <= 1'b0;
    end else begin
      // Lookup below reads the pre-write table, so a same-cycle write is not seen.
      if (cfg_we && (int'(cfg_idx) < NR_KEY)) begin
        ent_valid[cfg_idx] <= 1'b1;
        ent_key[cfg_idx]   <= cfg_key;
        ent_data[cfg_idx]  <= cfg_data;
      end
      case (state)
        IDLE: begin
          if (found) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_id    <= gidx;
            rsp_hit   <= lk_hit;
            rsp_data  <= lk_hit ? lk_data : default_out;
`ifndef MUX_KEY_ARBITER_FIXED_PRIO_EN
            rr_ptr    <= gidx;
`endif
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_key_arbiter.sv
// Bench for mux_key_arbiter: directed scenarios plus random traffic against a table/queue model.
module tb_mux_key_arbiter;
  localparam int NR_REQ = 4, NR_KEY = 4, KEY_LEN = 2, DATA_LEN = 4;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NR_REQ-1:0]         req_valid;
  logic [NR_REQ*KEY_LEN-1:0] req_key;
  logic [NR_REQ-1:0]         req_ready;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [1:0]                rsp_id;
  logic [DATA_LEN-1:0]       rsp_data;
  logic                      rsp_hit;
  logic [DATA_LEN-1:0]       default_out;
  logic                      cfg_we;
  logic [1:0]                cfg_idx;
  logic [KEY_LEN-1:0]        cfg_key;
  logic [DATA_LEN-1:0]       cfg_data;

  int n_chk = 0;
  int n_err = 0;

  // model: table contents, busy flag, last served requester, held response
  bit              m_tv [NR_KEY];
  int              m_tk [NR_KEY];
  int              m_td [NR_KEY];
  bit              m_busy;
  int              m_last;
  int              m_id, m_data;
  bit              m_hit;

  mux_key_arbiter #(.NR_REQ(NR_REQ), .NR_KEY(NR_KEY), .KEY_LEN(KEY_LEN), .DATA_LEN(DATA_LEN)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_key(req_key), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_hit(rsp_hit), .default_out(default_out), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_key(cfg_key), .cfg_data(cfg_data));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int e = 0; e < NR_KEY; e++) begin
      m_tv[e] = 0; m_tk[e] = 0; m_td[e] = 0;
    end
    m_busy = 0;
    m_last = NR_REQ - 1;
  endtask

  // One clock: check outputs at negedge against the model, then advance the model at posedge.
  task automatic tick();
    int g, idx, key, od;
    bit hit;
    @(negedge clk);
    g = -1;
    if (!m_busy) begin
      for (int k = 0; k < NR_REQ; k++) begin
`ifdef MUX_KEY_ARBITER_FIXED_PRIO_EN
        idx = k;
`else
        idx = (m_last + 1 + k) % NR_REQ;
`endif
        if (g < 0 && req_valid[idx]) g = idx;
      end
    end
    chk("req_ready", 32'(req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
    chk("rsp_valid", 32'(rsp_valid), 32'(m_busy));
    if (m_busy) begin
      chk("rsp_id", 32'(rsp_id), m_id);
      chk("rsp_data", 32'(rsp_data), m_data);
      chk("rsp_hit", 32'(rsp_hit), 32'(m_hit));
    end
    hit = 0; od = 0; key = 0;
    if (g >= 0) begin
      key = int'(req_key[g*KEY_LEN +: KEY_LEN]);
      for (int e = 0; e < NR_KEY; e++)
        if (m_tv[e] && m_tk[e] == key) begin hit = 1; od = od | m_td[e]; end
    end
    @(posedge clk);
    if (rst) model_clear();
    else begin
      if (m_busy && rsp_ready) m_busy = 0;
      else if (!m_busy && g >= 0) begin
        m_busy = 1; m_id = g; m_hit = hit;
        m_data = hit ? od : int'(default_out);
`ifndef MUX_KEY_ARBITER_FIXED_PRIO_EN
        m_last = g;
`endif
      end
      if (cfg_we && int'(cfg_idx) < NR_KEY) begin
        m_tv[cfg_idx] = 1; m_tk[cfg_idx] = int'(cfg_key); m_td[cfg_idx] = int'(cfg_data);
      end
    end
    #1;
  endtask

  task automatic cfg_write(input int i, input int k, input int d);
    cfg_we = 1; cfg_idx = 2'(i); cfg_key = 2'(k); cfg_data = 4'(d);
    tick();
    cfg_we = 0;
  endtask

  // Single-requester lookup; leaves the response visible (not yet consumed).
  task automatic issue(input int r, input int k);
    req_valid = '0; req_valid[r] = 1'b1;
    req_key[r*KEY_LEN +: KEY_LEN] = 2'(k);
    tick();
    req_valid = '0;
  endtask

  initial begin
    int prev, g;
    logic [DATA_LEN-1:0] held;
    rst = 1; req_valid = '0; req_key = '0; rsp_ready = 1; default_out = 4'h5;
    cfg_we = 0; cfg_idx = '0; cfg_key = '0; cfg_data = '0;
    model_clear();
    tick(); tick();
    rst = 0;
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_id", 32'(rsp_id), 0);
    chk("rst_rsp_data", 32'(rsp_data), 0);
    chk("rst_rsp_hit", 32'(rsp_hit), 0);

    // empty table always misses
    issue(0, 3);
    chk("miss_after_rst_data", 32'(rsp_data), 32'h5);
    chk("miss_after_rst_hit", 32'(rsp_hit), 0);
    tick();

    cfg_write(0, 1, 4'h3);
    cfg_write(1, 2, 4'hA);
    req_valid = 4'b0001; req_key[1:0] = 2'd2; #1;
    chk("grant_same_cycle", 32'(req_ready), 32'b0001);
    tick(); req_valid = '0;
    chk("hit_valid", 32'(rsp_valid), 1);
    chk("hit_data", 32'(rsp_data), 32'hA);
    chk("hit_hit", 32'(rsp_hit), 1);
    chk("hit_id", 32'(rsp_id), 0);
    tick();

    issue(2, 3);
    chk("miss_data", 32'(rsp_data), 32'h5);
    chk("miss_hit", 32'(rsp_hit), 0);
    chk("miss_id", 32'(rsp_id), 2);
    tick();

    // all requesting: grants rotate, one accept every two cycles
    prev = 2;
    req_valid = 4'b1111; rsp_ready = 1;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (req_ready != 0) begin
        g = 0;
        for (int i = 0; i < NR_REQ; i++) if (req_ready[i]) g = i;
`ifdef MUX_KEY_ARBITER_FIXED_PRIO_EN
        chk("rr_seq", g, 0);
`else
        chk("rr_seq", g, (prev + 1) % NR_REQ);
`endif
        prev = g;
      end
      tick();
    end
    req_valid = '0;
    while (m_busy) tick();

    // back-pressure
    rsp_ready = 0;
    issue(1, 2);
    held = rsp_data;
    for (int c = 0; c < 5; c++) begin
      req_valid = 4'b1111;
      tick();
      chk("stall_valid", 32'(rsp_valid), 1);
      chk("stall_data", 32'(rsp_data), 32'(held));
    end
    req_valid = '0;
    rsp_ready = 1;
    tick();
    chk("stall_release", 32'(rsp_valid), 0);

    // same-cycle write and lookup sees old contents
    cfg_we = 1; cfg_idx = 2'd0; cfg_key = 2'd1; cfg_data = 4'hC;
    issue(0, 1);
    cfg_we = 0;
    chk("old_contents", 32'(rsp_data), 32'h3);
    tick();
    issue(3, 1);
    chk("new_contents", 32'(rsp_data), 32'hC);
    tick();
    cfg_write(2, 1, 4'h1);
    issue(1, 1);
    chk("or_dup", 32'(rsp_data), 32'hD);
    chk("or_dup_hit", 32'(rsp_hit), 1);

    // reset while holding a response
    rst = 1; tick(); rst = 0;
    chk("rst_resp_valid", 32'(rsp_valid), 0);
    req_valid = 4'b1111; #1;
    chk("rst_prio", 32'(req_ready), 32'b0001);
    req_valid = '0;
    issue(0, 1);
    chk("rst_table_cleared", 32'(rsp_hit), 0);
    tick();

    for (int c = 0; c < 600; c++) begin
      rst         = ($urandom_range(0, 59) == 0);
      req_valid   = 4'($urandom);
      req_key     = 8'($urandom);
      rsp_ready   = ($urandom_range(0, 3) != 0);
      default_out = 4'($urandom);
      cfg_we      = ($urandom_range(0, 3) == 0);
      cfg_idx     = 2'($urandom);
      cfg_key     = 2'($urandom);
      cfg_data    = 4'($urandom);
      tick();
    end
    rst = 0; cfg_we = 0; req_valid = '0;
    tick();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
